// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter unit.
// Select encodings, FSM states and the default reset vector.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_REL  = 2'b01,
        PC_JALR = 2'b10,
        PC_TRAP = 2'b11
    } pc_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

    // Number of low address bits that must be zero for a given alignment.
    function automatic int ialign_bits(input int ialign);
        return (ialign == 2) ? 1 : 2;
    endfunction

endpackage

// File: rtl/pc_target_gen.sv
// Next-PC target selection and misalignment detection.
// Purely combinational; all arithmetic wraps modulo 2^XLEN.
module pc_target_gen
    import pc_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4
) (
    input  logic [1:0]      i_sel,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_trap_vec,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic [XLEN-1:0] o_target,
    output logic            o_misalign
);

    localparam int AB = ialign_bits(IALIGN);
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);
    localparam logic [XLEN-1:0] AMASK = {{(XLEN-AB){1'b1}}, {AB{1'b0}}};

    pc_sel_e         w_sel;
    logic [XLEN-1:0] w_rel;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_jalr;
    logic [XLEN-1:0] w_trap;

    assign w_sel      = pc_sel_e'(i_sel);
    assign o_pc_plus4 = i_pc + FOUR;
    assign w_rel      = i_pc + i_imm;
    assign w_jalr_sum = i_rs1 + i_imm;
    assign w_jalr     = {w_jalr_sum[XLEN-1:1], 1'b0};
    assign w_trap     = i_trap_vec & AMASK;

    always_comb begin
        o_target = o_pc_plus4;
        unique case (w_sel)
            PC_SEQ:  o_target = o_pc_plus4;
            PC_REL:  o_target = w_rel;
            PC_JALR: o_target = w_jalr;
            PC_TRAP: o_target = w_trap;
        endcase
    end

    // Trap vectors are force-aligned above, so they can never fault.
    assign o_misalign = (w_sel != PC_TRAP) && (|(o_target & ~AMASK));

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, RUN/HALT FSM on misaligned
// targets, held fault address and a retired-update counter.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter int              IALIGN       = 4,
    parameter int              CNT_W        = 64
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             en,
    input  logic [1:0]       pc_sel,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  trap_vec,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             halted,
    output logic             fault,
    output logic [XLEN-1:0]  fault_addr,
    output logic [CNT_W-1:0] instret
);

    pc_state_e        r_state;
    pc_state_e        w_state_nxt;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_fault_addr;
    logic [CNT_W-1:0] r_instret;

    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_target;
    logic             w_misalign;
    logic             w_is_trap;
    logic             w_pc_we;
    logic             w_cnt_inc;
    logic             w_fault;

    pc_target_gen #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_tgen (
        .i_sel      (pc_sel),
        .i_pc       (r_pc),
        .i_imm      (imm),
        .i_rs1      (rs1),
        .i_trap_vec (trap_vec),
        .o_pc_plus4 (w_pc_plus4),
        .o_target   (w_target),
        .o_misalign (w_misalign)
    );

    assign w_is_trap = (pc_sel_e'(pc_sel) == PC_TRAP);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (en && w_misalign) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (en && w_is_trap) begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    // fault is a same-cycle strobe; gated by areset so it reads 0 in reset.
    always_comb begin
        w_pc_we   = 1'b0;
        w_cnt_inc = 1'b0;
        w_fault   = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (en) begin
                    if (w_misalign) begin
                        w_fault = areset;
                    end else begin
                        w_pc_we   = 1'b1;
                        w_cnt_inc = !w_is_trap;
                    end
                end
            end
            ST_HALT: begin
                w_pc_we = en && w_is_trap;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_pc <= RESET_VECTOR;
        end else if (w_pc_we) begin
            r_pc <= w_target;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_fault_addr <= '0;
        end else if (w_fault) begin
            r_fault_addr <= w_target;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_instret <= '0;
        end else if (w_cnt_inc) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign halted     = (r_state == ST_HALT);
    assign fault      = w_fault;
    assign fault_addr = r_fault_addr;
    assign instret    = r_instret;

endmodule

// File: tb/tb_pc_unit.sv
// Randomized bench for pc_unit: three instances (IALIGN 4/2, 4-bit
// counter) checked every cycle against a behavioural model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        areset;
    logic        en;
    logic [1:0]  pc_sel;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] trap_vec;

    logic [31:0] pc_o    [3];
    logic [31:0] pcp4_o  [3];
    logic        halt_o  [3];
    logic        fault_o [3];
    logic [31:0] fa_o    [3];
    logic [63:0] cnt_a;
    logic [63:0] cnt_b;
    logic [3:0]  cnt_c;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    logic [31:0] m_pc   [3];
    logic        m_halt [3];
    logic [31:0] m_fa   [3];
    logic [63:0] m_cnt  [3];

    int ia [3] = '{4, 2, 4};
    logic [63:0] cmask [3] = '{64'hFFFF_FFFF_FFFF_FFFF,
                               64'hFFFF_FFFF_FFFF_FFFF,
                               64'h0000_0000_0000_000F};

    always #5 clk = ~clk;

    pc_unit #(.IALIGN(4)) u_a (
        .clk(clk), .areset(areset), .en(en), .pc_sel(pc_sel),
        .imm(imm), .rs1(rs1), .trap_vec(trap_vec),
        .pc(pc_o[0]), .pc_plus4(pcp4_o[0]), .halted(halt_o[0]),
        .fault(fault_o[0]), .fault_addr(fa_o[0]), .instret(cnt_a)
    );

    pc_unit #(.IALIGN(2)) u_b (
        .clk(clk), .areset(areset), .en(en), .pc_sel(pc_sel),
        .imm(imm), .rs1(rs1), .trap_vec(trap_vec),
        .pc(pc_o[1]), .pc_plus4(pcp4_o[1]), .halted(halt_o[1]),
        .fault(fault_o[1]), .fault_addr(fa_o[1]), .instret(cnt_b)
    );

    pc_unit #(.IALIGN(4), .CNT_W(4)) u_c (
        .clk(clk), .areset(areset), .en(en), .pc_sel(pc_sel),
        .imm(imm), .rs1(rs1), .trap_vec(trap_vec),
        .pc(pc_o[2]), .pc_plus4(pcp4_o[2]), .halted(halt_o[2]),
        .fault(fault_o[2]), .fault_addr(fa_o[2]), .instret(cnt_c)
    );

    function automatic logic [31:0] mtgt(int k);
        case (pc_sel)
            2'd0:    return m_pc[k] + 32'd4;
            2'd1:    return m_pc[k] + imm;
            2'd2:    return (rs1 + imm) & 32'hFFFF_FFFE;
            default: return trap_vec & ~(32'(ia[k]) - 32'd1);
        endcase
    endfunction

    function automatic bit mmis(int k);
        logic [31:0] t;
        t = mtgt(k);
        return (pc_sel != 2'd3) && ((t % 32'(ia[k])) != 0);
    endfunction

    always @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int k = 0; k < 3; k++) begin
                m_pc[k]   <= 32'h0;
                m_halt[k] <= 1'b0;
                m_fa[k]   <= 32'h0;
                m_cnt[k]  <= 64'h0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!m_halt[k] && en) begin
                    if (mmis(k)) begin
                        m_fa[k]   <= mtgt(k);
                        m_halt[k] <= 1'b1;
                    end else begin
                        m_pc[k] <= mtgt(k);
                        if (pc_sel != 2'd3)
                            m_cnt[k] <= (m_cnt[k] + 64'd1) & cmask[k];
                    end
                end else if (m_halt[k] && en && pc_sel == 2'd3) begin
                    m_pc[k]   <= mtgt(k);
                    m_halt[k] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] cnt_of(int k);
        case (k)
            0:       return cnt_a;
            1:       return cnt_b;
            default: return {60'h0, cnt_c};
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("pc%0d", k), 64'(pc_o[k]), 64'(m_pc[k]));
                chk($sformatf("pcp4_%0d", k), 64'(pcp4_o[k]),
                    64'(m_pc[k] + 32'd4));
                chk($sformatf("halted%0d", k), 64'(halt_o[k]),
                    64'(m_halt[k]));
                chk($sformatf("fault%0d", k), 64'(fault_o[k]),
                    64'(areset && !m_halt[k] && en && mmis(k)));
                chk($sformatf("faddr%0d", k), 64'(fa_o[k]), 64'(m_fa[k]));
                chk($sformatf("instret%0d", k), cnt_of(k), m_cnt[k]);
            end
        end
    end

    task automatic drive(input logic e, input logic [1:0] s,
                         input logic [31:0] im, input logic [31:0] r,
                         input logic [31:0] tv);
        en = e; pc_sel = s; imm = im; rs1 = r; trap_vec = tv;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        areset = 1'b0;
        en = 1'b0; pc_sel = 2'd0; imm = '0; rs1 = '0; trap_vec = '0;
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b1;
        chk_on = 1'b1;
        #1;
        chk("rst_pc", 64'(pc_o[0]), 64'h0);
        chk("rst_halted", 64'(halt_o[0]), 64'h0);
        chk("rst_faddr", 64'(fa_o[0]), 64'h0);
        chk("rst_instret", cnt_a, 64'h0);

        repeat (3) begin drive(1, 0, 0, 0, 0); tick(); end
        chk("seq_pc", 64'(pc_o[0]), 64'hC);
        chk("seq_instret", cnt_a, 64'd3);
        chk("seq_pcp4", 64'(pcp4_o[0]), 64'h10);

        drive(1, 3, 0, 0, 32'h100); tick();
        drive(1, 1, 32'hFFFF_FFF0, 0, 0); tick();
        chk("rel_pc", 64'(pc_o[0]), 64'hF0);
        drive(1, 2, 32'h2, 32'h201, 0);
        chk("jalr_fault_a", 64'(fault_o[0]), 64'h1);
        chk("jalr_nofault_b", 64'(fault_o[1]), 64'h0);
        tick();
        chk("jalr_pc_a", 64'(pc_o[0]), 64'hF0);
        chk("jalr_faddr_a", 64'(fa_o[0]), 64'h202);
        chk("jalr_halt_a", 64'(halt_o[0]), 64'h1);
        chk("jalr_pc_b", 64'(pc_o[1]), 64'h202);
        drive(1, 0, 0, 0, 0); tick();
        chk("halt_hold_pc", 64'(pc_o[0]), 64'hF0);
        drive(1, 3, 0, 0, 32'h8000_0003); tick();
        chk("trap_pc_a", 64'(pc_o[0]), 64'h8000_0000);
        chk("trap_pc_b", 64'(pc_o[1]), 64'h8000_0002);
        chk("trap_halt_a", 64'(halt_o[0]), 64'h0);
        chk("trap_cnt_a", cnt_a, 64'd4);
        chk("trap_cnt_b", cnt_b, 64'd6);

        drive(1, 3, 0, 0, 32'h20); tick();
        drive(1, 1, 32'h6, 0, 0);
        chk("mis_fault", 64'(fault_o[0]), 64'h1);
        tick();
        chk("mis_faddr", 64'(fa_o[0]), 64'h26);
        chk("mis_pc", 64'(pc_o[0]), 64'h20);
        chk("mis_halted", 64'(halt_o[0]), 64'h1);
        chk("mis_pulse_end", 64'(fault_o[0]), 64'h0);

        drive(1, 3, 0, 0, 32'h40); tick();
        drive(1, 1, 32'h2, 0, 0); tick();
        chk("pre_rst_pc", 64'(pc_o[0]), 64'h40);
        areset = 1'b0;
        #1;
        chk("arst_pc", 64'(pc_o[0]), 64'h0);
        chk("arst_halted", 64'(halt_o[0]), 64'h0);
        chk("arst_faddr", 64'(fa_o[0]), 64'h0);
        chk("arst_cnt", cnt_a, 64'h0);
        tick();
        areset = 1'b1;

        repeat (3) begin drive(0, 0, 0, 0, 0); tick(); end
        chk("en0_pc", 64'(pc_o[0]), 64'h0);
        chk("en0_cnt", cnt_a, 64'h0);
        repeat (17) begin drive(1, 0, 0, 0, 0); tick(); end
        chk("wrap_cnt_c", {60'h0, cnt_c}, 64'd1);
        chk("wrap_cnt_a", cnt_a, 64'd17);
        chk("wrap_pc", 64'(pc_o[0]), 64'h44);

        repeat (3000) begin
            if ($urandom_range(0, 199) == 0) begin
                areset = 1'b0;
                tick();
                areset = 1'b1;
            end
            if ($urandom_range(0, 3) == 0)
                imm = $urandom;
            else
                imm = 32'($signed(5'($urandom_range(0, 31))));
            en       = ($urandom_range(0, 9) < 8);
            pc_sel   = 2'($urandom_range(0, 3));
            rs1      = $urandom;
            trap_vec = $urandom;
            tick();
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
